// File: rtl/rram_op_sequencer_if.sv
// Wishbone slave bundle between the bus master and the RRAM op sequencer.
interface rram_op_sequencer_if;
  logic [31:0] wishbone_data_in;
  logic [31:0] wishbone_address_bus;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic [31:0] wishbone_data_out;

  modport master (
    output wishbone_data_in, wishbone_address_bus, wbs_we_i, wbs_stb_i,
    input  wbs_ack_o, wishbone_data_out
  );

  modport slave (
    input  wishbone_data_in, wishbone_address_bus, wbs_we_i, wbs_stb_i,
    output wbs_ack_o, wishbone_data_out
  );
endinterface

// File: rtl/rram_op_sequencer.sv
// Wishbone-driven sequencer producing timed READ/SET/RESET/MAC switch-matrix
// enables and ADC strobes for the RRAM compute macro.
module rram_op_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned PRE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  rram_op_sequencer_if.slave        wb,
  input  logic [3:0]                adc_in,
  output logic [1:0]                wl_en,
  output logic [1:0]                bl_en,
  output logic [1:0]                sl_en,
  output logic                      pre_en,
  output logic [1:0]                mode,
  output logic                      adc_sample,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRECHARGE, S_PULSE, S_SETTLE, S_SAMPLE, S_CAPTURE, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_SET, OP_RESET, OP_MAC} op_t;

  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR;
  localparam logic [31:0] TIMING_ADDR = BASE_ADDR + 32'h4;
  localparam logic [31:0] RESULT_ADDR = BASE_ADDR + 32'h8;
  localparam logic [7:0]  PRE_LAST    = (PRE_CYCLES > 1) ? 8'(PRE_CYCLES - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack, wr_q;
  logic [31:0] addr_q, rdata_q, rd_mux;
  logic [15:0] wdata_q;
  logic [7:0]  pulse_cfg, settle_cfg, pulse_last, settle_last;
  logic [7:0]  pw_q, sw_q;
  op_t         op_q, start_op;
  logic        row_q, col_q;
  logic [3:0]  code;
  logic        valid, err, done_sticky;
  logic        accept, ctrl_wr, timing_wr, start_req, can_start, start_go, sense;
  logic [1:0]  row_mask, col_mask;

  assign accept       = wb.wbs_stb_i & ~ack;
  assign wb.wbs_ack_o = ack;
  assign wb.wishbone_data_out = rdata_q;

  // Writes take effect in the ack cycle, so an accepted START raises busy one cycle later.
  assign ctrl_wr   = wr_q && (addr_q == CTRL_ADDR);
  assign timing_wr = wr_q && (addr_q == TIMING_ADDR);
  assign start_req = ctrl_wr & wdata_q[0];
  assign start_op  = op_t'(wdata_q[2:1]);
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_go  = start_req & can_start;

  assign pulse_last  = (pulse_cfg == 8'd0)  ? 8'd0 : pulse_cfg - 8'd1;
  assign settle_last = (settle_cfg == 8'd0) ? 8'd0 : settle_cfg - 8'd1;

  assign sense    = (op_q == OP_READ) || (op_q == OP_MAC);
  assign row_mask = row_q ? 2'b10 : 2'b01;
  assign col_mask = col_q ? 2'b10 : 2'b01;

  assign busy = ~can_start;
  assign mode = busy ? op_q : 2'b00;

  always_comb begin
    rd_mux = '0;
    case (wb.wishbone_address_bus)
      CTRL_ADDR:   rd_mux = {26'd0, op_q, err, valid, done_sticky, busy};
      TIMING_ADDR: rd_mux = {16'd0, settle_cfg, pulse_cfg};
      RESULT_ADDR: rd_mux = {23'd0, valid, 4'd0, code};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack     <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ack  <= accept;
      wr_q <= accept & wb.wbs_we_i;
      if (accept) begin
        addr_q  <= wb.wishbone_address_bus;
        wdata_q <= wb.wishbone_data_in[15:0];
        rdata_q <= wb.wbs_we_i ? '0 : rd_mux;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cfg   <= 8'h04;
      settle_cfg  <= 8'h04;
      op_q        <= OP_READ;
      row_q       <= 1'b0;
      col_q       <= 1'b0;
      pw_q        <= '0;
      sw_q        <= '0;
      code        <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      if (timing_wr) begin
        pulse_cfg  <= wdata_q[7:0];
        settle_cfg <= wdata_q[15:8];
      end
      if (state_q == S_CAPTURE) begin
        code  <= adc_in;
        valid <= 1'b1;
      end
      if (state_q == S_DONE)
        done_sticky <= 1'b1;
      if (start_go) begin
        op_q        <= start_op;
        row_q       <= wdata_q[3];
        col_q       <= wdata_q[4];
        pw_q        <= pulse_last;
        sw_q        <= settle_last;
        valid       <= 1'b0;
        done_sticky <= 1'b0;
      end
      if (start_req && !can_start)
        err <= 1'b1;
      else if (ctrl_wr && !wdata_q[0] && wdata_q[3])
        err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wl_en      = '0;
    bl_en      = '0;
    sl_en      = '0;
    pre_en     = 1'b0;
    adc_sample = 1'b0;
    done       = 1'b0;
    case (state_q)
      // DONE can launch the next START directly so a back-to-back command is not lost.
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start_go) begin
          if (start_op == OP_READ || start_op == OP_MAC) begin
            state_d = S_PRECHARGE;
            cnt_d   = PRE_LAST;
          end else begin
            state_d = S_PULSE;
            cnt_d   = pulse_last;
          end
        end
      end
      S_PRECHARGE: begin
        pre_en = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = S_PULSE;
          cnt_d   = pw_q;
        end else
          cnt_d = cnt_q - 8'd1;
      end
      S_PULSE: begin
        wl_en = (op_q == OP_MAC) ? 2'b11 : row_mask;
        if (op_q == OP_RESET)
          sl_en = col_mask;
        else
          bl_en = col_mask;
        if (cnt_q == 8'd0) begin
          state_d = S_SETTLE;
          cnt_d   = sw_q;
        end else
          cnt_d = cnt_q - 8'd1;
      end
      S_SETTLE: begin
        if (sense) begin
          wl_en = (op_q == OP_MAC) ? 2'b11 : row_mask;
          bl_en = col_mask;
        end
        if (cnt_q == 8'd0)
          state_d = sense ? S_SAMPLE : S_DONE;
        else
          cnt_d = cnt_q - 8'd1;
      end
      S_SAMPLE: begin
        wl_en      = (op_q == OP_MAC) ? 2'b11 : row_mask;
        bl_en      = col_mask;
        adc_sample = 1'b1;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Directed bench for rram_op_sequencer: per-cycle timeline model plus literal checks.
module tb_rram_op_sequencer;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] CTRL   = BASE;
  localparam logic [31:0] TIMING = BASE + 32'h4;
  localparam logic [31:0] RESULT = BASE + 32'h8;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] adc = 4'h0;
  logic [1:0] wl_en, bl_en, sl_en, mode;
  logic       pre_en, adc_sample, busy, done;

  rram_op_sequencer_if bus();

  rram_op_sequencer #(.BASE_ADDR(BASE), .PRE_CYCLES(P)) dut (
    .clk(clk), .rst(rst_n), .wb(bus), .adc_in(adc),
    .wl_en(wl_en), .bl_en(bl_en), .sl_en(sl_en), .pre_en(pre_en),
    .mode(mode), .adc_sample(adc_sample), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: an operation is a timeline measured from the START ack cycle.
  logic        m_active = 1'b0;
  int          m_t0 = 0;
  logic [1:0]  m_op = 2'b00;
  logic        m_row = 1'b0, m_col = 1'b0;
  int          m_pw = 1, m_sw = 1;
  logic [15:0] m_timing = 16'h0404;
  logic [3:0]  m_code = 4'h0;
  logic        m_valid = 1'b0, m_err = 1'b0, m_dsticky = 1'b0;
  logic [1:0]  m_oplast = 2'b00;

  int cnt_pre, cnt_adc, cnt_en, cnt_sl, cnt_mode, done_cyc;

  function automatic logic is_sense(input logic [1:0] op);
    return (op == 2'b00) || (op == 2'b11);
  endfunction

  function automatic int done_k();
    return is_sense(m_op) ? P + m_pw + m_sw + 3 : m_pw + m_sw + 1;
  endfunction

  function automatic logic [31:0] model_ctrl();
    return {26'd0, m_oplast, m_err, m_valid, m_dsticky, 1'b0};
  endfunction

  function automatic logic [31:0] model_result();
    return {23'd0, m_valid, 4'd0, m_code};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_pre = 0; cnt_adc = 0; cnt_en = 0; cnt_sl = 0; cnt_mode = 0; done_cyc = -1;
  endtask

  always @(negedge clk) begin : cmp
    logic [1:0] e_wl, e_bl, e_sl, e_mode;
    logic       e_pre, e_adc, e_busy, e_done;
    int k, d, s_end;
    e_wl = '0; e_bl = '0; e_sl = '0; e_mode = '0;
    e_pre = 1'b0; e_adc = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    k = 0; d = 0; s_end = 0;
    if (m_active) begin
      k = cyc - m_t0;
      d = done_k();
      if (is_sense(m_op)) begin
        s_end = P + m_pw + m_sw + 1;
        e_pre = (k >= 1 && k <= P);
        if (k > P && k <= s_end) begin
          e_wl = (m_op == 2'b11) ? 2'b11 : (m_row ? 2'b10 : 2'b01);
          e_bl = m_col ? 2'b10 : 2'b01;
        end
        e_adc = (k == s_end);
      end else if (k >= 1 && k <= m_pw) begin
        e_wl = m_row ? 2'b10 : 2'b01;
        if (m_op == 2'b01) e_bl = m_col ? 2'b10 : 2'b01;
        else               e_sl = m_col ? 2'b10 : 2'b01;
      end
      e_busy = (k >= 1 && k < d);
      e_done = (k == d);
      e_mode = e_busy ? m_op : 2'b00;
    end
    checks++;
    if ({wl_en, bl_en, sl_en, pre_en, mode, adc_sample, busy, done} !==
        {e_wl, e_bl, e_sl, e_pre, e_mode, e_adc, e_busy, e_done}) begin
      errors++;
      $display("FAIL outputs cyc=%0d actual wl=%b bl=%b sl=%b pre=%b mode=%b adc=%b busy=%b done=%b required wl=%b bl=%b sl=%b pre=%b mode=%b adc=%b busy=%b done=%b",
               cyc, wl_en, bl_en, sl_en, pre_en, mode, adc_sample, busy, done,
               e_wl, e_bl, e_sl, e_pre, e_mode, e_adc, e_busy, e_done);
    end
    cnt_pre  += int'(pre_en);
    cnt_adc  += int'(adc_sample);
    cnt_en   += int'(wl_en != 2'b00);
    cnt_sl   += int'(sl_en != 2'b00);
    cnt_mode += int'(mode != 2'b00);
    if (done) done_cyc = cyc;
    if (m_active) begin
      if (is_sense(m_op) && k == P + m_pw + m_sw + 2) begin
        m_code  = adc;
        m_valid = 1'b1;
      end
      if (k == d) begin
        m_active  = 1'b0;
        m_dsticky = 1'b1;
      end
    end
  end

  task automatic wb_write(input logic [31:0] a, input logic [31:0] dat);
    int k;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wishbone_address_bus = a; bus.wishbone_data_in = dat;
    @(posedge clk); #1;
    chk("ack_wr", {31'd0, bus.wbs_ack_o}, 32'd1);
    if (a == TIMING) m_timing = dat[15:0];
    if (a == CTRL) begin
      k = cyc - m_t0;
      if (dat[0]) begin
        if (m_active && k >= 1 && k < done_k()) m_err = 1'b1;
        else begin
          m_active = 1'b1; m_t0 = cyc; m_op = dat[2:1];
          m_row = dat[3]; m_col = dat[4];
          m_pw = (m_timing[7:0] == 8'd0) ? 1 : int'(m_timing[7:0]);
          m_sw = (m_timing[15:8] == 8'd0) ? 1 : int'(m_timing[15:8]);
          m_valid = 1'b0; m_dsticky = 1'b0; m_oplast = dat[2:1];
        end
      end else if (dat[3]) m_err = 1'b0;
    end
    @(negedge clk);
    bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] dat);
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wishbone_address_bus = a;
    @(posedge clk); #1;
    chk("ack_rd", {31'd0, bus.wbs_ack_o}, 32'd1);
    dat = bus.wishbone_data_out;
    @(negedge clk);
    bus.wbs_stb_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && m_active; i++) @(negedge clk);
    if (m_active) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int t_start;
    bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wishbone_address_bus = '0; bus.wishbone_data_in = '0;
    clr_cnt();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_rdata", bus.wishbone_data_out, 32'd0);
    rst_n = 1'b1;

    wb_read(CTRL, rd);   chk("rst_ctrl", rd, 32'h0);
    wb_read(TIMING, rd); chk("rst_timing", rd, 32'h0000_0404);
    wb_read(RESULT, rd); chk("rst_result", rd, 32'h0);
    wb_read(BASE + 32'h40, rd); chk("unmapped_rd", rd, 32'h0);

    // READ row1 col0, pulse 2, settle 3
    wb_write(TIMING, 32'h0000_0302);
    adc = 4'hA;
    clr_cnt();
    wb_write(CTRL, 32'h9);
    t_start = m_t0;
    wait_idle();
    chk("read_pre_cycles", cnt_pre, 2);
    chk("read_wlbl_cycles", cnt_en, 6);
    chk("read_adc_strobes", cnt_adc, 1);
    chk("read_latency", done_cyc - t_start, 10);
    wb_read(RESULT, rd); chk("read_result", rd, 32'h10A);
    chk("read_result_model", rd, model_result());
    wb_read(CTRL, rd); chk("read_ctrl", rd, 32'h6);
    chk("read_ctrl_model", rd, model_ctrl());

    // RESET col1, pulse 5, settle 1
    wb_write(TIMING, 32'h0000_0105);
    clr_cnt();
    wb_write(CTRL, 32'h15);
    t_start = m_t0;
    wait_idle();
    chk("reset_sl_cycles", cnt_sl, 5);
    chk("reset_adc_strobes", cnt_adc, 0);
    chk("reset_mode_cycles", cnt_mode, 6);
    chk("reset_latency", done_cyc - t_start, 7);
    wb_read(RESULT, rd); chk("reset_result", rd, 32'h00A);
    chk("reset_result_model", rd, model_result());

    // MAC row0 col1, pulse 4, settle 2, with a START while busy
    wb_write(TIMING, 32'h0000_0204);
    adc = 4'h5;
    clr_cnt();
    wb_write(CTRL, 32'h17);
    wb_write(CTRL, 32'h1);
    wait_idle();
    chk("mac_wl_cycles", cnt_en, 7);
    chk("mac_adc_strobes", cnt_adc, 1);
    wb_read(RESULT, rd); chk("mac_result", rd, 32'h105);
    chk("mac_result_model", rd, model_result());
    wb_read(CTRL, rd); chk("mac_ctrl_err", rd, 32'h3E);
    chk("mac_ctrl_model", rd, model_ctrl());
    wb_write(CTRL, 32'h8);
    wb_read(CTRL, rd); chk("err_clear", rd, 32'h36);
    wb_write(BASE + 32'h40, 32'hFFFF_FFFF);
    wb_write(RESULT, 32'hFFFF_FFFF);
    wb_read(RESULT, rd); chk("result_ro", rd, 32'h105);

    // SET with TIMING=0 runs 1-cycle pulse and settle
    wb_write(TIMING, 32'h0);
    wb_read(TIMING, rd); chk("timing_zero", rd, 32'h0);
    clr_cnt();
    wb_write(CTRL, 32'h3);
    t_start = m_t0;
    wait_idle();
    chk("set0_pulse_cycles", cnt_en, 1);
    chk("set0_latency", done_cyc - t_start, 3);

    // Reset asserted during a SET pulse
    wb_write(TIMING, 32'h0000_0108);
    wb_write(CTRL, 32'h3);
    repeat (3) @(negedge clk);
    chk("pulse_before_rst", {28'd0, wl_en, bl_en}, 32'h5);
    #2 rst_n = 1'b0;
    m_active = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_dsticky = 1'b0;
    m_code = 4'h0; m_oplast = 2'b00; m_timing = 16'h0404;
    #1;
    chk("rst_async_en", {26'd0, wl_en, bl_en, sl_en}, 32'h0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read(RESULT, rd); chk("post_rst_result", rd, 32'h0);
    chk("post_rst_result_model", rd, model_result());
    wb_read(CTRL, rd); chk("post_rst_ctrl", rd, model_ctrl());
    wb_read(TIMING, rd); chk("post_rst_timing", rd, {16'd0, m_timing});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
